// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: decodes a scanned common-anode 7-seg bus into per-digit BCD; SEG7_DP_EN adds decimal-point capture
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [6:0]              iSeg,
  input  logic [NUM_DIGITS-1:0]   iAn,
  input  logic                    iClr,
`ifdef SEG7_DP_EN
  input  logic                    iDp,
  output logic [NUM_DIGITS-1:0]   oDp,
`endif
  output logic [4*NUM_DIGITS-1:0] oDigits,
  output logic [NUM_DIGITS-1:0]   oValid,
  output logic                    oUpdate,
  output logic                    oBad,
  output logic                    oFrame
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
`ifdef SEG7_DP_EN
  localparam int PW = NUM_DIGITS + 8;
  logic [PW-1:0] pair;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  assign pair = {iDp, iAn, iSeg};
  assign oDp  = dp_q;
`else
  localparam int PW = NUM_DIGITS + 7;
  logic [PW-1:0] pair;
  assign pair = {iAn, iSeg};
`endif
  state_t state_q, state_d;
  logic [7:0] count_q, count_d, count_inc;
  logic [PW-1:0] prev_q;
  logic [NUM_DIGITS-1:0] an_n, seen_q, seen_d, seen_n, valid_q, valid_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic single, match, cap, good, frame, upd_q, bad_q, frame_q;
  logic [4:0] dec;
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'd0;
      7'b1111001: decode = 5'd1;
      7'b0100100: decode = 5'd2;
      7'b0110000: decode = 5'd3;
      7'b0011001: decode = 5'd4;
      7'b0010010: decode = 5'd5;
      7'b0000010: decode = 5'd6;
      7'b1111000: decode = 5'd7;
      7'b0000000: decode = 5'd8;
      7'b0010000: decode = 5'd9;
      default:    decode = 5'h10;
    endcase
  endfunction
  assign an_n      = ~iAn;
  assign single    = (|an_n) && ~|(an_n & (an_n - 1'b1));
  assign match     = pair == prev_q;
  assign count_inc = count_q + 8'd1;
  assign dec       = decode(iSeg);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (single) begin
        state_d = SETTLE;
        count_d = 8'd1;
      end
      SETTLE: if (!single) begin
        state_d = IDLE;
        count_d = '0;
      end else if (!match) begin
        count_d = 8'd1;
      end else begin
        count_d = count_inc;
        cap     = count_inc == STABLE;
        state_d = cap ? HOLD : SETTLE;
      end
      HOLD: if (!single) begin
        state_d = IDLE;
        count_d = '0;
      end else if (!match) begin
        state_d = SETTLE;
        count_d = 8'd1;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end
  // an_n is one-hot whenever cap is set, so it doubles as the digit write mask
  always_comb begin
    good    = cap && !dec[4];
    seen_n  = (iClr ? '0 : seen_q) | (good ? an_n : '0);
    frame   = good && &seen_n;
    seen_d  = frame ? '0 : seen_n;
    valid_d = (iClr ? '0 : valid_q) | (good ? an_n : '0);
    digits_d = digits_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (good && an_n[i]) digits_d[4*i +: 4] = dec[3:0];
`ifdef SEG7_DP_EN
    dp_d = good ? ((dp_q & iAn) | (iDp ? '0 : an_n)) : dp_q;
`endif
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      prev_q   <= '1;
      seen_q   <= '0;
      valid_q  <= '0;
      digits_q <= '0;
      upd_q    <= 1'b0;
      bad_q    <= 1'b0;
      frame_q  <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      prev_q   <= pair;
      seen_q   <= seen_d;
      valid_q  <= valid_d;
      digits_q <= digits_d;
      upd_q    <= good;
      bad_q    <= cap && dec[4];
      frame_q  <= frame;
`ifdef SEG7_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end
  assign oDigits = digits_q;
  assign oValid  = valid_q;
  assign oUpdate = upd_q;
  assign oBad    = bad_q;
  assign oFrame  = frame_q;
endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Observes a multiplexed, common-anode 7-segment bus (active-low segment lines plus active-low digit enables).
- Reconstructs the BCD value shown on each digit by inverting the team's segment encoding.
- Used as a loopback checker behind the display driver and as a front-end for reading external panels into the core.
- Filters scan transitions and ghosting with a stability counter, and reports per-digit values, validity, update and error pulses.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (2..255).

Ports:
- iClk  input  1  system clock; all logic is on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iSeg  input  7  segment lines, active-low; bit6..bit0 = g,f,e,d,c,b,a.
- iAn  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i.
- iClr  input  1  clears oValid and the frame-seen mask.
- oDigits  output  4*NUM_DIGITS  captured BCD per digit; digit i occupies bits [4i+3:4i].
- oValid  output  NUM_DIGITS  digit i holds a capture since the last clear.
- oUpdate  output  1  one-cycle pulse on each good capture.
- oBad  output  1  one-cycle pulse on each capture of an undecodable pattern.
- oFrame  output  1  one-cycle pulse when every digit has been captured since the last frame or clear.

Behaviour:
- Reset (iRst=1 at an edge):
  - All outputs go to 0. State goes to IDLE, stability count to 0, seen mask to 0, and the previous-sample registers to all-ones.
  - Reset overrides every other event in the same cycle.
- Decode table (iSeg → value):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - Any other pattern is "bad".
- Single-select condition: exactly one bit of iAn is 0.
- Every edge, {iAn,iSeg} is registered as the previous sample. The pair "matches" when it equals the previous sample.
- State machine:
  - IDLE: count=0. On single-select, set count=1 and go to SETTLE.
  - SETTLE:
    - If not single-select → go to IDLE with count=0.
    - Else if no match → count=1, stay in SETTLE.
    - Else count+1. When the new count equals STABLE_CYCLES, perform a capture and go to HOLD.
  - HOLD: no further captures. On any mismatch or loss of single-select, re-enter SETTLE (count=1) or IDLE respectively.
- Latency: a pair first present at edge k and held is captured at edge k+STABLE_CYCLES-1. Outputs reflect the capture after that edge.
- Good capture at digit i:
  - oDigits[i] takes the decoded value and oValid[i] is set.
  - Seen-mask bit i is set and oUpdate pulses.
- Bad capture: oBad pulses. oDigits, oValid, the seen mask and oUpdate are unchanged.
- Frame:
  - When a good capture makes the seen mask all-ones, oFrame pulses in the same cycle as that oUpdate, and the seen mask clears to 0.
  - Repeated captures of an already-seen digit only refresh its value.
- iClr:
  - Clears oValid and the seen mask. oDigits retain their values.
  - If iClr coincides with a good capture on digit i, bit i of oValid and of the seen mask is set; all other bits are cleared. oFrame does not pulse unless NUM_DIGITS=1.
- Scan blanking (all iAn high) and ghosting (two or more iAn low) never capture, and force IDLE.
- Segment changes while in HOLD restart stability on the same digit, so a value change without an anode change is captured after STABLE_CYCLES.

Optional Feature:
- Macro: SEG7_DP_EN.
- When defined:
  - Adds input iDp (1 bit, active-low decimal point) and output oDp (NUM_DIGITS bits, reset 0).
  - iDp is part of the matched pair.
  - On a good capture, oDp[i] = ~iDp. Bad captures leave oDp unchanged.
- When undefined: neither port exists, and the decimal point is neither sampled nor matched.

Test Plan:
- Reset then hold iAn=1110, iSeg=0110000 for 4 cycles → after the 4th edge: oDigits[3:0]=3, oValid=0001, oUpdate pulses once. Holding 10 more cycles produces no further pulses.
- Hold iAn=1101, iSeg=0110000 for 3 cycles, then change to iAn=1011 → no capture on digit 1; oValid unchanged.
- Scan digits 0..3 with values 1,2,4,9, each for 5 cycles with a 2-cycle all-ones blank → four oUpdate pulses; oFrame coincides with the 4th; oDigits=16'h9421; oValid=1111.
- Hold iAn=1110, iSeg=1111111 for 4 cycles → oBad pulses; oValid[0] and oDigits[3:0] unchanged.
- Assert iClr on the capture edge of digit 2 (value 7), with oValid previously 1011 → oValid=0100, oDigits[11:8]=7, no oFrame.
- Assert iRst mid-SETTLE after 2 matched cycles, then release and keep the same inputs → capture occurs exactly 4 edges after release; all outputs read 0 during reset.
